// File: rtl/sd_dma_master.sv
// sd_dma_master: byte-bus DMA initiator for the SD host data path.
// dir=0 fetches memory bytes into a TX FIFO that feeds the SD data engine.
// dir=1 stores bytes taken from the SD RX stream into memory.
// Only one bus command is outstanding at a time. An optional circular
// window (wrap_len) folds the address offset back to zero.
// Optional feature macro: SD_DMA_XFER_CNT_EN adds the xfer_cnt output
// (bytes completed on the bus in the current transfer).
module sd_dma_master #(
  parameter int ADDR_W     = 17,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              bus_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [LEN_W-1:0]  wrap_len,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tx_dat,
  output logic              tx_vld,
  input  logic              tx_rdy,
  input  logic [7:0]        rx_dat,
  input  logic              rx_vld,
  output logic              rx_rdy,
  input  logic              bus_ready,
  input  logic              bus_rdata_ready,
  input  logic [7:0]        bus_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr
`ifdef SD_DMA_XFER_CNT_EN
  ,
  output logic [LEN_W-1:0]  xfer_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR,
    FIN
  } state_t;

  state_t            state_q;
  logic              dir_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  wrap_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  offset_q;
  logic [LEN_W-1:0]  offset_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              wr_q;
  logic              wr_skip_q;
  logic [7:0]        wdata_q;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              rd_complete;
  logic              wr_complete;
  logic              beat_done;
  logic              wr_accept;

`ifdef SD_DMA_XFER_CNT_EN
  logic [LEN_W-1:0]  xfer_cnt_q;
  assign xfer_cnt = xfer_cnt_q;
`endif

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign tx_vld      = !fifo_empty;
  assign tx_dat      = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q];
  assign pop         = tx_vld && tx_rdy;

  assign rd_complete = (state_q == WAIT_RD) && bus_rdata_ready;
  assign wr_complete = (state_q == WAIT_WR) && !wr_skip_q && bus_ready;
  assign beat_done   = rd_complete || wr_complete;
  assign push        = rd_complete;

  assign rx_rdy      = (state_q == ISSUE) && dir_q && bus_ready;
  assign wr_accept   = rx_rdy && rx_vld;

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus_rd      = rd_q;
  assign bus_wr      = wr_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;

  // Next offset inside the optional circular window, and the address it maps to.
  always_comb begin
    offset_d = offset_q + LEN_W'(1);
    if ((wrap_q != '0) && (offset_q == wrap_q - LEN_W'(1))) begin
      offset_d = '0;
    end
    addr_d = base_q + ADDR_W'(offset_d);
  end

  // FIFO occupancy: a simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Transfer sequencer with registered bus command, status and address outputs.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      base_q      <= '0;
      wrap_q      <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wr_skip_q   <= 1'b0;
      wdata_q     <= '0;
`ifdef SD_DMA_XFER_CNT_EN
      xfer_cnt_q  <= '0;
`endif
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef SD_DMA_XFER_CNT_EN
      if (beat_done) begin
        xfer_cnt_q <= xfer_cnt_q + LEN_W'(1);
      end
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_q       <= dir;
            base_q      <= start_addr;
            wrap_q      <= wrap_len;
            remaining_q <= xfer_len;
            offset_q    <= '0;
            addr_q      <= start_addr;
            busy_q      <= 1'b1;
`ifdef SD_DMA_XFER_CNT_EN
            xfer_cnt_q  <= '0;
`endif
            state_q     <= (xfer_len == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (!dir_q) begin
            if (bus_ready && !fifo_full) begin
              rd_q    <= 1'b1;
              state_q <= WAIT_RD;
            end
          end else if (wr_accept) begin
            wdata_q   <= rx_dat;
            wr_q      <= 1'b1;
            wr_skip_q <= 1'b1;
            state_q   <= WAIT_WR;
          end
        end
        WAIT_RD, WAIT_WR: begin
          wr_skip_q <= 1'b0;
          if (beat_done) begin
            remaining_q <= remaining_q - LEN_W'(1);
            offset_q    <= offset_d;
            addr_q      <= addr_d;
            state_q     <= (remaining_q == LEN_W'(1)) ? FIN : ISSUE;
          end
        end
        FIN: begin
          if (dir_q || fifo_empty) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // TX FIFO pointers and count; reset flushes all buffered bytes.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // TX FIFO storage; contents are meaningless while the count is zero.
  always_ff @(posedge bus_clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_sd_dma_master.sv
// tb_sd_dma_master: directed and randomized transfers for sd_dma_master
// against a 6-cycle memory responder and an address/data reference model.
module tb_sd_dma_master;

  localparam int ADDR_W     = 17;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int MEM_SIZE   = 1 << ADDR_W;
  localparam int RSP_DELAY  = 6;

  logic              bus_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  xfer_len;
  logic [LEN_W-1:0]  wrap_len;
  logic              busy;
  logic              done;
  logic [7:0]        tx_dat;
  logic              tx_vld;
  logic              tx_rdy;
  logic [7:0]        rx_dat;
  logic              rx_vld;
  logic              rx_rdy;
  logic              bus_ready;
  logic              bus_rdata_ready;
  logic [7:0]        bus_rdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_rd;
  logic              bus_wr;
`ifdef SD_DMA_XFER_CNT_EN
  logic [LEN_W-1:0]  xfer_cnt;
`endif

  sd_dma_master #(
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .bus_clk         (bus_clk),
    .rst             (rst),
    .start           (start),
    .dir             (dir),
    .start_addr      (start_addr),
    .xfer_len        (xfer_len),
    .wrap_len        (wrap_len),
    .busy            (busy),
    .done            (done),
    .tx_dat          (tx_dat),
    .tx_vld          (tx_vld),
    .tx_rdy          (tx_rdy),
    .rx_dat          (rx_dat),
    .rx_vld          (rx_vld),
    .rx_rdy          (rx_rdy),
    .bus_ready       (bus_ready),
    .bus_rdata_ready (bus_rdata_ready),
    .bus_rdata       (bus_rdata),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rd          (bus_rd),
    .bus_wr          (bus_wr)
`ifdef SD_DMA_XFER_CNT_EN
    ,
    .xfer_cnt        (xfer_cnt)
`endif
  );

  // Free-running bus clock.
  always #5 bus_clk = ~bus_clk;

  // Memory responder: busy for 6 cycles after each command, read data strobed on the last.
  int                rspCnt = 0;
  logic              rspIsRd;
  logic [ADDR_W-1:0] rspAddr;
  logic [7:0]        mem [MEM_SIZE];

  assign bus_ready = (rspCnt == 0);

  always @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      rspCnt          <= 0;
      rspIsRd         <= 1'b0;
      rspAddr         <= '0;
      bus_rdata_ready <= 1'b0;
      bus_rdata       <= 8'h00;
    end else begin
      bus_rdata_ready <= 1'b0;
      if (rspCnt != 0) begin
        rspCnt <= rspCnt - 1;
        if (rspCnt == 1 && rspIsRd) begin
          bus_rdata_ready <= 1'b1;
          bus_rdata       <= mem[rspAddr];
        end
      end else if (bus_rd) begin
        rspCnt  <= RSP_DELAY;
        rspIsRd <= 1'b1;
        rspAddr <= bus_addr;
      end else if (bus_wr) begin
        rspCnt  <= RSP_DELAY;
        rspIsRd <= 1'b0;
        mem[bus_addr] = bus_wdata;
      end
    end
  end

  // Bus and stream monitors logging every command, pop and accepted RX byte.
  int                rdPulses = 0;
  int                wrPulses = 0;
  int                doneCnt = 0;
  int                rxAccCnt = 0;
  int                spacingViol = 0;
  bit                prevPulse = 1'b0;
  logic [ADDR_W-1:0] rdAddrQ[$];
  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [7:0]        wrDataQ[$];
  logic [7:0]        txQ[$];

  always @(posedge bus_clk) begin
    if ((bus_rd || bus_wr) && prevPulse) spacingViol++;
    prevPulse = bus_rd || bus_wr;
    if (bus_rd) begin
      rdPulses++;
      rdAddrQ.push_back(bus_addr);
    end
    if (bus_wr) begin
      wrPulses++;
      wrAddrQ.push_back(bus_addr);
      wrDataQ.push_back(bus_wdata);
    end
    if (done) doneCnt++;
    if (tx_vld && tx_rdy) txQ.push_back(tx_dat);
    if (rx_vld && rx_rdy) rxAccCnt++;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rxBytes[$];
  int         rxBase = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference address of byte k: start plus offset, offset folded into the window.
  function automatic logic [ADDR_W-1:0] modelAddr(input logic [ADDR_W-1:0] sa, input int k, input int wrap);
    int off;
    off = (wrap != 0) ? (k % wrap) : k;
    return ADDR_W'((int'(sa) + off) % MEM_SIZE);
  endfunction

  function automatic logic [31:0] rdAddrAt(input int i);
    return (i < rdAddrQ.size()) ? 32'(rdAddrQ[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wrAddrAt(input int i);
    return (i < wrAddrQ.size()) ? 32'(wrAddrQ[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wrDataAt(input int i);
    return (i < wrDataQ.size()) ? 32'(wrDataQ[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] txAt(input int i);
    return (i < txQ.size()) ? 32'(txQ[i]) : 32'hxxxx_xxxx;
  endfunction

  task automatic driveRx();
    int idx;
    idx = rxAccCnt - rxBase;
    if (idx < rxBytes.size()) begin
      rx_vld = 1'b1;
      rx_dat = rxBytes[idx];
    end else begin
      rx_vld = 1'b0;
      rx_dat = 8'h00;
    end
  endtask

  task automatic applyStimulus(input logic d, input logic [ADDR_W-1:0] a, input int len, input int wrap);
    @(negedge bus_clk);
    dir        = d;
    start_addr = a;
    xfer_len   = LEN_W'(len);
    wrap_len   = LEN_W'(wrap);
    start      = 1'b1;
    @(negedge bus_clk);
    start      = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, input bit randTx);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge bus_clk);
      driveRx();
      if (randTx) tx_rdy = 1'($urandom_range(0, 1));
      if (done) seen = 1'b1;
      cyc++;
    end
    checkOutput({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic checkRead(input string tag, input logic [ADDR_W-1:0] sa, input int len, input int wrap,
                           input int rdBase, input int txBase);
    logic [ADDR_W-1:0] a;
    checkOutput({tag, " tx count"}, 32'(txQ.size() - txBase), 32'(len));
    for (int k = 0; k < len; k++) begin
      a = modelAddr(sa, k, wrap);
      checkOutput($sformatf("%s addr[%0d]", tag, k), rdAddrAt(rdBase + k), 32'(a));
      checkOutput($sformatf("%s data[%0d]", tag, k), txAt(txBase + k), 32'(mem[a]));
    end
  endtask

  task automatic checkWrite(input string tag, input logic [ADDR_W-1:0] sa, input int len, input int wrap,
                            input int wrBase);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = modelAddr(sa, k, wrap);
      checkOutput($sformatf("%s waddr[%0d]", tag, k), wrAddrAt(wrBase + k), 32'(a));
      checkOutput($sformatf("%s wdata[%0d]", tag, k), wrDataAt(wrBase + k), 32'(rxBytes[k]));
      if (wrap == 0 || k + wrap >= len) begin
        checkOutput($sformatf("%s mem[%0d]", tag, k), 32'(mem[a]), 32'(rxBytes[k]));
      end
    end
  endtask

  task automatic checkEnd(input string tag, input int dnBase, input int cmdBase, input int len);
    checkOutput({tag, " cmd count"}, 32'(rdPulses + wrPulses - cmdBase), 32'(len));
`ifdef SD_DMA_XFER_CNT_EN
    checkOutput({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(len));
`endif
    @(negedge bus_clk);
    checkOutput({tag, " one done"}, 32'(doneCnt - dnBase), 32'd1);
    checkOutput({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  // Directed scenarios followed by randomized transfers, all checked against the model.
  initial begin
    int    rdB, txB, wrB, dnB, cmdB, p0, p1, cyc;
    logic  d;
    logic [ADDR_W-1:0] sa;
    int    len, wrap;
    string tag;

    start = 1'b0; dir = 1'b0; start_addr = '0; xfer_len = '0; wrap_len = '0;
    tx_rdy = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge bus_clk);
    checkOutput("reset ctrl", {26'd0, busy, done, bus_rd, bus_wr, rx_rdy, tx_vld}, 32'd0);
    checkOutput("reset addr", 32'(bus_addr), 32'd0);
    checkOutput("reset wdata", 32'(bus_wdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge bus_clk);

    // Plain 4-byte read
    tx_rdy = 1'b1;
    rxBytes.delete(); rxBase = rxAccCnt;
    rdB = rdAddrQ.size(); txB = txQ.size(); dnB = doneCnt; cmdB = rdPulses + wrPulses;
    applyStimulus(1'b0, 17'h00100, 4, 0);
    checkOutput("rd4 busy", 32'(busy), 32'd1);
    waitDone("rd4", 400, 1'b0);
    checkRead("rd4", 17'h00100, 4, 0, rdB, txB);
    checkEnd("rd4", dnB, cmdB, 4);

    // 5-byte write crossing the top of the address space
    rxBytes.delete();
    for (int k = 0; k < 5; k++) rxBytes.push_back(8'(8'hA0 + k));
    rxBase = rxAccCnt;
    wrB = wrAddrQ.size(); dnB = doneCnt; cmdB = rdPulses + wrPulses;
    applyStimulus(1'b1, 17'h1FFFE, 5, 0);
    waitDone("wr5", 400, 1'b0);
    checkWrite("wr5", 17'h1FFFE, 5, 0, wrB);
    checkOutput("wr5 mem 0x00002", 32'(mem[2]), 32'h0000_00A4);
    checkEnd("wr5", dnB, cmdB, 5);

    // 10-byte read in a 4-byte circular window
    rxBytes.delete(); rxBase = rxAccCnt;
    rdB = rdAddrQ.size(); txB = txQ.size(); dnB = doneCnt; cmdB = rdPulses + wrPulses;
    applyStimulus(1'b0, 17'h00200, 10, 4);
    waitDone("wrap", 400, 1'b0);
    checkRead("wrap", 17'h00200, 10, 4, rdB, txB);
    checkEnd("wrap", dnB, cmdB, 10);

    // Backpressure: FIFO fills to its depth and reads stall
    tx_rdy = 1'b0;
    rdB = rdAddrQ.size(); txB = txQ.size(); dnB = doneCnt; cmdB = rdPulses + wrPulses;
    applyStimulus(1'b0, 17'h00400, 12, 0);
    repeat (150) @(negedge bus_clk);
    checkOutput("bp stalled reads", 32'(rdAddrQ.size() - rdB), 32'(FIFO_DEPTH));
    checkOutput("bp tx_vld", 32'(tx_vld), 32'd1);
    checkOutput("bp busy", 32'(busy), 32'd1);
    tx_rdy = 1'b1;
    waitDone("bp", 400, 1'b0);
    checkRead("bp", 17'h00400, 12, 0, rdB, txB);
    checkEnd("bp", dnB, cmdB, 12);

    // Zero-length transfer
    p0 = rdPulses + wrPulses; dnB = doneCnt;
    applyStimulus(1'b0, 17'h00500, 0, 0);
    checkOutput("zero early", {30'd0, busy, done}, 32'd2);
    @(negedge bus_clk);
    checkOutput("zero done", {30'd0, busy, done}, 32'd1);
    repeat (5) @(negedge bus_clk);
    checkOutput("zero no cmds", 32'(rdPulses + wrPulses - p0), 32'd0);
    checkOutput("zero one done", 32'(doneCnt - dnB), 32'd1);

    // Reset during WAIT_RD, then a clean transfer
    p0 = rdPulses;
    applyStimulus(1'b0, 17'h00600, 6, 0);
    cyc = 0;
    while (rdPulses == p0 && cyc < 50) begin
      @(negedge bus_clk);
      cyc++;
    end
    checkOutput("rst first read", 32'(rdPulses - p0), 32'd1);
    repeat (2) @(negedge bus_clk);
    rst = 1'b1;
    p1 = rdPulses + wrPulses;
    @(negedge bus_clk);
    checkOutput("rst ctrl", {26'd0, busy, done, bus_rd, bus_wr, rx_rdy, tx_vld}, 32'd0);
    checkOutput("rst addr", 32'(bus_addr), 32'd0);
    checkOutput("rst wdata", 32'(bus_wdata), 32'd0);
    repeat (3) @(negedge bus_clk);
    rst = 1'b0;
    repeat (20) @(negedge bus_clk);
    checkOutput("rst no cmds", 32'(rdPulses + wrPulses - p1), 32'd0);
    checkOutput("rst idle", 32'(busy), 32'd0);
    rdB = rdAddrQ.size(); txB = txQ.size(); dnB = doneCnt; cmdB = rdPulses + wrPulses;
    applyStimulus(1'b0, 17'h00600, 6, 0);
    waitDone("post rst", 400, 1'b0);
    checkRead("post rst", 17'h00600, 6, 0, rdB, txB);
    checkEnd("post rst", dnB, cmdB, 6);

    // Randomized transfers with random direction, window and consumer stalls
    for (int it = 0; it < 6; it++) begin
      d    = 1'($urandom_range(0, 1));
      sa   = ADDR_W'($urandom);
      len  = $urandom_range(1, 9);
      wrap = $urandom_range(0, 4);
      tag  = $sformatf("rnd%0d", it);
      rxBytes.delete();
      if (d) begin
        for (int k = 0; k < len; k++) rxBytes.push_back(8'($urandom));
      end
      rxBase = rxAccCnt;
      tx_rdy = 1'b1;
      rdB = rdAddrQ.size(); txB = txQ.size(); wrB = wrAddrQ.size();
      dnB = doneCnt; cmdB = rdPulses + wrPulses;
      applyStimulus(d, sa, len, wrap);
      waitDone(tag, 800, 1'b1);
      tx_rdy = 1'b1;
      if (d) checkWrite(tag, sa, len, wrap, wrB);
      else   checkRead(tag, sa, len, wrap, rdB, txB);
      checkEnd(tag, dnB, cmdB, len);
    end

    checkOutput("cmd spacing", 32'(spacingViol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
